// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO load/shift sequencer.
package piso_pkg;

    localparam int WIDTH_DEF      = 4;
    localparam int GAP_CYCLES_DEF = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_e;

endpackage

// File: rtl/piso_ctrl.sv
// Handshake front end and load/shift sequencer driving a WIDTH-bit PISO via pi/sel.
// Define PISO_CTRL_WCNT_EN to add the saturating words_sent counter output.
//
// state | meaning
// IDLE  | no word in flight, waiting for the holding register to fill
// LOAD  | one cycle of parallel load of the held word (sel=0)
// SHIFT | WIDTH cycles of serial shift (sel=1, so_valid=1)
// GAP   | GAP_CYCLES idle cycles between consecutive words
module piso_ctrl
    import piso_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] pi,
    output logic             sel,
    output logic             so_valid,
    output logic             done,
    output logic             busy
`ifdef PISO_CTRL_WCNT_EN
    ,
    output logic [7:0]       words_sent
`endif
);

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] BITS_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [3:0]    GAP_INIT  = 4'(GAP_CYCLES);

    state_e           state_q, state_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic [WIDTH-1:0] pi_q, pi_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;

    logic             accept;
    logic             word_avail;
    logic [WIDTH-1:0] next_word;

    assign in_ready   = clr_n & ~hold_full_q;
    assign accept     = in_valid & in_ready & ~flush;
    // A word arriving on the same edge counts, so LOAD never waits an extra cycle.
    assign word_avail = hold_full_q | accept;
    assign next_word  = hold_full_q ? hold_data_q : in_data;

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        pi_d        = pi_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;

        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = in_data;
        end

        case (state_q)
            IDLE: begin
                if (word_avail) begin
                    state_d = LOAD;
                    pi_d    = next_word;
                end
            end
            LOAD: begin
                hold_full_d = 1'b0;
                cnt_d       = BITS_INIT;
                state_d     = SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_INIT;
                    end else if (word_avail) begin
                        state_d = LOAD;
                        pi_d    = next_word;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q == 4'd1) begin
                    if (word_avail) begin
                        state_d = LOAD;
                        pi_d    = next_word;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d     = IDLE;
            hold_full_d = 1'b0;
            pi_d        = '0;
            cnt_d       = '0;
            gap_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            pi_q        <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            pi_q        <= pi_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
        end
    end

    assign pi       = pi_q;
    assign sel      = (state_q == SHIFT);
    assign so_valid = (state_q == SHIFT);
    assign done     = (state_q == SHIFT) && (cnt_q == CNT_ONE);
    assign busy     = (state_q != IDLE);

`ifdef PISO_CTRL_WCNT_EN
    logic [7:0] words_q, words_d;

    always_comb begin
        words_d = words_q;
        if (done && (words_q != 8'hFF)) begin
            words_d = words_q + 8'd1;
        end
    end

    // Flush deliberately leaves the count alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            words_q <= 8'd0;
        end else begin
            words_q <= words_d;
        end
    end

    assign words_sent = words_q;
`endif

endmodule

// File: doc/piso_ctrl.md
PISO_CTRL -- requirements
Module: piso_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, PISO word width in bits (2..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 0, idle cycles inserted between words (0..15).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port clr_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port flush  input  1  synchronous abort of the current word and held word.
REQ-006 SHALL have port in_valid  input  1  in_data is offered.
REQ-007 SHALL have port in_data  input  WIDTH  parallel word to serialize.
REQ-008 SHALL have port in_ready  output  1  holding register empty; word is accepted when in_valid and in_ready are both high at an edge.
REQ-009 SHALL have port pi  output  WIDTH  parallel data driven to the PISO.
REQ-010 SHALL have port sel  output  1  PISO mode: 0 = parallel load, 1 = shift one bit per clock.
REQ-011 SHALL have port so_valid  output  1  PISO serial output carries a data bit this cycle.
REQ-012 SHALL have port done  output  1  one-cycle pulse on the last shift cycle of a word.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SHIFT, GAP.
REQ-015 SHALL hold one accepted word in a 1-entry holding register; in_ready = holding register empty.
REQ-016 IDLE: sel=0, so_valid=0; go to LOAD when the holding register is full.
REQ-017 LOAD: lasts exactly 1 cycle; pi = held word, sel=0; the holding register empties at the end of LOAD; then go to SHIFT.
REQ-018 SHIFT: lasts exactly WIDTH cycles; sel=1, so_valid=1; pi holds the loaded word; a down-counter sized $clog2(WIDTH+1) tracks remaining bits.
REQ-019 done SHALL be 1 only in the final SHIFT cycle.
REQ-020 After the final SHIFT cycle, go to GAP if GAP_CYCLES>0; otherwise go to LOAD if the holding register is full, else IDLE.
REQ-021 GAP: lasts exactly GAP_CYCLES cycles with sel=0 and so_valid=0; then go to LOAD if the holding register is full, else IDLE.
REQ-022 A new word SHALL be acceptable during LOAD/SHIFT/GAP once the holding register has emptied, so back-to-back words with GAP_CYCLES=0 produce no idle cycle between the last SHIFT and the next LOAD.
REQ-023 Latency: word accepted at edge T means LOAD occupies cycle T+1 and SHIFT occupies cycles T+2..T+1+WIDTH, when the FSM is in IDLE at T.
REQ-024 flush SHALL, at the next edge, force IDLE, empty the holding register, and clear the counter and pi; flush has priority over a simultaneous handshake, and the offered word is dropped.

Reset
REQ-025 While clr_n=0 at an edge, the block SHALL enter IDLE with pi=0, sel=0, so_valid=0, done=0, busy=0, holding register empty, counter=0.
REQ-026 in_ready SHALL be 0 while clr_n is low and 1 in the first cycle after reset release.
REQ-027 Reset mid-word SHALL discard the word without a done pulse.

Configuration
REQ-028 With macro PISO_CTRL_WCNT_EN defined, the block SHALL add output words_sent[7:0], which increments at each done edge, saturates at 255, and is cleared by reset only (not by flush).
REQ-029 Without PISO_CTRL_WCNT_EN, the port and counter SHALL be absent.

Structure
REQ-030 Shared package piso_pkg SHALL hold the FSM state enum (IDLE/LOAD/SHIFT/GAP) and the WIDTH/GAP_CYCLES default constants.
REQ-031 SHALL be a single module with no sub-module; it drives the existing 4-bit PISO via pi/sel, and integration instantiates both side by side.

Verification
REQ-032 Reset, then send 4'b1110 -> pi=1110/sel=0 for 1 cycle, then sel=1/so_valid=1 for 4 cycles, done on the 4th, busy drops the cycle after.
REQ-033 Send 4'b1110 then 4'b0110 with in_valid held high -> second LOAD directly follows the 4th SHIFT; sel sequence 0,1,1,1,1,0,1,1,1,1.
REQ-034 With GAP_CYCLES=2, send two words -> exactly 2 cycles of sel=0/so_valid=0 between the last SHIFT and the second LOAD.
REQ-035 Assert flush in the 2nd SHIFT cycle with a word held -> IDLE next cycle, in_ready=1, no done, held word never loaded.
REQ-036 Drive clr_n=0 for 1 cycle mid-SHIFT -> all outputs match REQ-025 the next cycle, and a new word sent afterwards serializes normally.
REQ-037 With PISO_CTRL_WCNT_EN defined, send 260 words -> words_sent reads 255 and stays 255; a flush leaves it at 255.
